// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch_sequencer (master) and the fetch/execute side (slave).
interface fetch_seq_if #(
    parameter int ADDR_W = 9,
    parameter int INST_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [INST_W-1:0] inst;
    logic              exec_done;
    logic              br_taken;
    logic              br_rel;
    logic [7:0]        br_target;
    logic [5:0]        br_imm;
    logic              init;
    logic [ADDR_W-1:0] startAddress;
    logic              fetch_unit_en;
    logic              branch;
    logic              branchi;
    logic [7:0]        target;
    logic [5:0]        immediate;
    logic              inst_valid;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [15:0]       cycle_cnt;

    modport master (
        input  start, start_addr, inst, exec_done, br_taken, br_rel, br_target, br_imm,
        output init, startAddress, fetch_unit_en, branch, branchi, target, immediate,
               inst_valid, busy, done, timeout, cycle_cnt
    );

    modport slave (
        output start, start_addr, inst, exec_done, br_taken, br_rel, br_target, br_imm,
        input  init, startAddress, fetch_unit_en, branch, branchi, target, immediate,
               inst_valid, busy, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/issue/wait control FSM for fetch_unit. Optional watchdog: define FETCH_SEQ_WATCHDOG_EN
// to force HALT with timeout once cycle_cnt reaches WDOG_LIMIT.
module fetch_sequencer #(
    parameter int                 ADDR_W      = 9,
    parameter int                 INST_W      = 9,
    parameter logic [INST_W-1:0]  HALT_OPCODE = {{(INST_W-1){1'b0}}, 1'b1}
`ifdef FETCH_SEQ_WATCHDOG_EN
    , parameter logic [15:0]      WDOG_LIMIT  = 16'd65535
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_seq_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_HALT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_start_addr;
    logic [15:0]       r_cnt;
    logic              r_timeout;
    logic              w_run;
    logic              w_wdog;
    logic              w_adv;
    logic              w_accept;

    assign w_run    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_HALT)) && bus.start;

`ifdef FETCH_SEQ_WATCHDOG_EN
    assign w_wdog = w_run && (r_cnt >= WDOG_LIMIT);
`else
    assign w_wdog = 1'b0;
`endif

    // PC advances only when the datapath finished and the watchdog did not fire
    assign w_adv = (r_state == S_WAIT) && bus.exec_done && !w_wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_start_addr <= '0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_run && !w_wdog && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
`ifdef FETCH_SEQ_WATCHDOG_EN
            if (w_wdog)
                r_timeout <= 1'b1;
`endif
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_accept) begin
                        r_start_addr <= bus.start_addr;
                        r_cnt        <= '0;
                        r_timeout    <= 1'b0;
                        r_state      <= S_INIT;
                    end
                end
                S_INIT:  r_state <= S_ISSUE;
                S_ISSUE: begin
                    if (w_wdog || bus.inst == HALT_OPCODE)
                        r_state <= S_HALT;
                    else
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_wdog)
                        r_state <= S_HALT;
                    else if (bus.exec_done)
                        r_state <= S_ISSUE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.init          = (r_state == S_INIT);
    assign bus.fetch_unit_en = (r_state == S_INIT) || w_adv;
    assign bus.inst_valid    = (r_state == S_ISSUE);
    assign bus.busy          = (r_state == S_INIT) || w_run;
    assign bus.done          = (r_state == S_HALT);
    assign bus.branch        = w_adv && bus.br_taken && !bus.br_rel;
    assign bus.branchi       = w_adv && bus.br_taken && bus.br_rel;
    // Branch operands are don't-care outside an advance; gating keeps them 0 in reset
    assign bus.target        = w_adv ? bus.br_target : 8'd0;
    assign bus.immediate     = w_adv ? bus.br_imm : 6'd0;
    assign bus.startAddress  = r_start_addr;
    assign bus.cycle_cnt     = r_cnt;
`ifdef FETCH_SEQ_WATCHDOG_EN
    assign bus.timeout       = r_timeout;
`else
    assign bus.timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small fetch_unit PC model feeding inst.
module tb_fetch_sequencer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_iv;
    int   n_init;
    logic [8:0] pc;
    logic [8:0] mem [0:511];

    fetch_seq_if #(.ADDR_W(9), .INST_W(9)) bus ();

`ifdef FETCH_SEQ_WATCHDOG_EN
    fetch_sequencer #(.WDOG_LIMIT(16'd8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fetch_unit model: init loads, en advances or branches
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (bus.init) pc <= bus.startAddress;
        else if (bus.fetch_unit_en) begin
            if (bus.branch)       pc <= {1'b0, bus.target};
            else if (bus.branchi) pc <= pc + {3'b000, bus.immediate};
            else                  pc <= pc + 9'd1;
        end
    end
    assign bus.inst = mem[pc];

    always @(negedge clk) begin
        if (bus.inst_valid) n_iv++;
        if (bus.init)       n_init++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max);
        int k;
        k = 0;
        while (bus.done !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("wait_done", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic wait_iv(input int max);
        int k;
        k = 0;
        while (bus.inst_valid !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("wait_iv", {31'd0, bus.inst_valid}, 32'd1);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_iv = 0; n_init = 0;
        for (int i = 0; i < 512; i++) mem[i] = 9'h100;
        mem[5] = 9'h001;
        rst_n = 1'b1;
        bus.start = 0; bus.start_addr = '0; bus.exec_done = 0;
        bus.br_taken = 0; bus.br_rel = 0; bus.br_target = '0; bus.br_imm = '0;

        // T1: reset mid-clock
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctl", {24'd0, bus.init, bus.fetch_unit_en, bus.branch, bus.branchi,
                        bus.inst_valid, bus.busy, bus.done, bus.timeout}, 32'd0);
        chk("rst_cnt", {16'd0, bus.cycle_cnt}, 32'd0);
        chk("rst_sa_tgt", {9'd0, bus.startAddress, bus.target, bus.immediate}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // T2: straight-line program, HALT at 5
        step();
        n_iv = 0; n_init = 0;
        bus.start = 1; bus.start_addr = 9'd0; bus.exec_done = 1;
        step();
        bus.start = 0;
        wait_done(100);
        chk("t2_iv", n_iv, 32'd6);
        chk("t2_init", n_init, 32'd1);
        chk("t2_cnt", {16'd0, bus.cycle_cnt}, 32'd11);
        chk("t2_busy", {31'd0, bus.busy}, 32'd0);

        // T3: absolute branch
        step();
        bus.start = 1; bus.start_addr = 9'd0; bus.exec_done = 0;
        step();
        bus.start = 0;
        wait_iv(10);
        step();
        bus.exec_done = 1; bus.br_taken = 1; bus.br_rel = 0; bus.br_target = 8'h20;
        @(negedge clk);
        chk("t3_br", {30'd0, bus.branch, bus.branchi}, 32'd2);
        chk("t3_tgt", {24'd0, bus.target}, 32'h20);
        chk("t3_en", {31'd0, bus.fetch_unit_en}, 32'd1);
        step();
        bus.exec_done = 0; bus.br_taken = 0;
        @(negedge clk);
        chk("t3_iv", {31'd0, bus.inst_valid}, 32'd1);
        chk("t3_pc", {23'd0, pc}, 32'h20);

        // T4: stall 3 cycles, start while busy ignored, then relative branch
        step();
        bus.start = 1; bus.start_addr = 9'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall", {30'd0, bus.fetch_unit_en, bus.inst_valid}, 32'd0);
            step();
            bus.start = 0;
        end
        bus.exec_done = 1; bus.br_taken = 1; bus.br_rel = 1; bus.br_imm = 6'd3;
        @(negedge clk);
        chk("t4_br", {30'd0, bus.branch, bus.branchi}, 32'd1);
        chk("t4_imm", {26'd0, bus.immediate}, 32'd3);
        chk("t4_en", {31'd0, bus.fetch_unit_en}, 32'd1);
        chk("t4_sa", {23'd0, bus.startAddress}, 32'd0);
        step();
        bus.exec_done = 0; bus.br_taken = 0;
        @(negedge clk);
        chk("t4_iv", {31'd0, bus.inst_valid}, 32'd1);
        chk("t4_pc", {23'd0, pc}, 32'h23);
        step();
        @(negedge clk);
        chk("t4_iv_once", {30'd0, bus.inst_valid, bus.busy}, 32'd1);

        // T5: reset during WAIT, then restart at 2
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst", {29'd0, bus.done, bus.busy, bus.init}, 32'd0);
        chk("t5_cnt", {16'd0, bus.cycle_cnt}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        n_iv = 0;
        bus.start = 1; bus.start_addr = 9'd2; bus.exec_done = 1;
        step();
        bus.start = 0;
        @(negedge clk);
        chk("t5_init", {30'd0, bus.init, bus.fetch_unit_en}, 32'd3);
        chk("t5_sa", {23'd0, bus.startAddress}, 32'd2);
        wait_done(100);
        chk("t5_iv", n_iv, 32'd4);
        chk("t5_cnt_end", {16'd0, bus.cycle_cnt}, 32'd7);

        // T6: exec_done never arrives
        step();
        bus.start = 1; bus.start_addr = 9'd0; bus.exec_done = 0;
        step();
        bus.start = 0;
`ifdef FETCH_SEQ_WATCHDOG_EN
        wait_done(50);
        chk("t6_timeout", {31'd0, bus.timeout}, 32'd1);
        chk("t6_cnt", {16'd0, bus.cycle_cnt}, 32'd8);
`else
        repeat (20) @(negedge clk);
        chk("t6_hold", {29'd0, bus.busy, bus.done, bus.timeout}, 32'd4);
        chk("t6_en", {31'd0, bus.fetch_unit_en}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
